// File: rtl/uart_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : uart_arb_pkg                                               |
// | Description : Shared definitions for the UART transmit arbiter: FSM      |
// |               state encoding, requester-ID width helper and the default  |
// |               header tag nibble.                                         |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package uart_arb_pkg;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] c_StIdle  = 3'd0;
  localparam logic [STATE_W-1:0] c_StHdr   = 3'd1;
  localparam logic [STATE_W-1:0] c_StIssue = 3'd2;
  localparam logic [STATE_W-1:0] c_StStart = 3'd3;
  localparam logic [STATE_W-1:0] c_StWait  = 3'd4;

  localparam logic [3:0] c_HdrTagDefault = 4'hA;

  // Width of a requester index; never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : rr_arbiter                                                 |
// | Description : Combinational round-robin picker. Returns the first set    |
// |               request at or after the priority pointer, wrapping modulo  |
// |               NUM_REQ. The pointer register lives in the parent.         |
// | Ports       : i_reqVec   [NUM_REQ]  request vector                       |
// |               i_rrPtr    [ID_W]     highest-priority index               |
// |               o_winner   [ID_W]     selected index (0 when none)         |
// |               o_anyValid            at least one request is set          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module rr_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int ID_W = idWidth(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_reqVec,
  input  logic [ID_W-1:0]    i_rrPtr,
  output logic [ID_W-1:0]    o_winner,
  output logic               o_anyValid
);

  int              w_sum;
  logic [ID_W-1:0] w_idx;

  // Scan from the farthest offset down to the pointer so that the candidate
  // closest to the pointer is the last one written and therefore wins.
  always_comb begin
    o_winner   = '0;
    o_anyValid = 1'b0;
    w_sum      = 0;
    w_idx      = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      w_sum = int'(i_rrPtr) + off;
      if (w_sum >= NUM_REQ) begin
        w_sum = w_sum - NUM_REQ;
      end
      w_idx = ID_W'(w_sum);
      if (i_reqVec[w_idx]) begin
        o_winner   = w_idx;
        o_anyValid = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_tx_arbiter                                            |
// | Description : Shares one UART byte transmitter between NUM_REQ byte-     |
// |               stream requesters. Round-robin grant per packet; the grant |
// |               is held until req_last or MAX_BURST bytes (0 = unlimited). |
// |               Bytes go out one at a time over the start/data/busy        |
// |               handshake.                                                 |
// | Ports       : clk, rst (sync, active-high)                               |
// |               req_valid/req_data/req_last/req_ready  requester side      |
// |               tx_start/tx_data/tx_busy               transmitter side    |
// |               grant_id, active                       grant status        |
// | Config      : UART_ARB_HEADER_EN - when defined, every grant first sends |
// |               the header byte {HDR_TAG, grant_id}.                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int         NUM_REQ   = 4,
  parameter int         MAX_BURST = 64,
  parameter logic [3:0] HDR_TAG   = c_HdrTagDefault,
  localparam int        ID_W      = idWidth(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 active
);

  localparam int              BCW           = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam logic [BCW-1:0]  c_BurstLimit  = BCW'(MAX_BURST);
  localparam logic [ID_W-1:0] c_LastId      = ID_W'(NUM_REQ - 1);

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_nextState;
  logic [ID_W-1:0]    r_rrPtr;
  logic [ID_W-1:0]    r_grantId;
  logic [ID_W-1:0]    w_winner;
  logic               w_anyValid;
  logic               r_active;
  logic [BCW-1:0]     r_burstCnt;
  logic [7:0]         r_capData;
  logic               r_capLast;
  logic               r_isHdr;     // byte in flight is the header, not payload
  logic               r_waitFirst; // first WAIT cycle, before tx_busy has risen
  logic               w_accept;
  logic               w_waitDone;
  logic               w_burstHit;
  logic               w_release;
  logic [7:0]         w_reqByte;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rrArbiter (
    .i_reqVec   (req_valid),
    .i_rrPtr    (r_rrPtr),
    .o_winner   (w_winner),
    .o_anyValid (w_anyValid)
  );

  assign w_reqByte  = req_data[{r_grantId, 3'b000} +: 8];
  assign w_accept   = (r_state == c_StIssue) && !tx_busy && req_valid[r_grantId];
  assign w_burstHit = (MAX_BURST != 0) && (r_burstCnt == c_BurstLimit);
  assign w_waitDone = (r_state == c_StWait) && !r_waitFirst && !tx_busy;
  assign w_release  = w_waitDone && !r_isHdr && (r_capLast || w_burstHit);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_StIdle;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      c_StIdle: begin
        if (w_anyValid) begin
`ifdef UART_ARB_HEADER_EN
          w_nextState = c_StHdr;
`else
          w_nextState = c_StIssue;
`endif
        end
      end
      c_StHdr: begin
        if (!tx_busy) w_nextState = c_StStart;
      end
      c_StIssue: begin
        if (w_accept) w_nextState = c_StStart;
      end
      c_StStart: begin
        w_nextState = c_StWait;
      end
      c_StWait: begin
        if (w_waitDone) w_nextState = w_release ? c_StIdle : c_StIssue;
      end
      default: begin
        w_nextState = c_StIdle;
      end
    endcase
  end

  // Output logic
  always_comb begin
    req_ready = '0;
    if (w_accept) req_ready[r_grantId] = 1'b1;
    tx_start = (r_state == c_StStart);
    tx_data  = (r_state == c_StStart) ? r_capData : 8'h00;
    grant_id = r_grantId;
    active   = r_active;
  end

  // Grant, capture and burst bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rrPtr     <= '0;
      r_grantId   <= '0;
      r_active    <= 1'b0;
      r_burstCnt  <= '0;
      r_capData   <= 8'h00;
      r_capLast   <= 1'b0;
      r_isHdr     <= 1'b0;
      r_waitFirst <= 1'b0;
    end else begin
      case (r_state)
        c_StIdle: begin
          if (w_anyValid) begin
            r_grantId <= w_winner;
            r_active  <= 1'b1;
          end
        end
        c_StHdr: begin
          if (!tx_busy) begin
            r_capData <= {HDR_TAG, 4'(r_grantId)};
            r_capLast <= 1'b0;
            r_isHdr   <= 1'b1;
          end
        end
        c_StIssue: begin
          if (w_accept) begin
            r_capData <= w_reqByte;
            r_capLast <= req_last[r_grantId];
            r_isHdr   <= 1'b0;
          end
        end
        c_StStart: begin
          r_waitFirst <= 1'b1;
          // Saturating count; header bytes are not payload.
          if (!r_isHdr && (r_burstCnt != '1)) r_burstCnt <= r_burstCnt + 1'b1;
        end
        c_StWait: begin
          r_waitFirst <= 1'b0;
          if (w_release) begin
            r_active   <= 1'b0;
            r_burstCnt <= '0;
            // Releasing owner drops to lowest priority for the next grant.
            r_rrPtr    <= (r_grantId == c_LastId) ? '0 : r_grantId + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_tx_arbiter                                         |
// | Description : Directed self-checking bench for uart_tx_arbiter with a    |
// |               10-cycle transmitter busy model and FIFO-fed requesters.   |
// |               Honours UART_ARB_HEADER_EN for expected header bytes.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_uart_tx_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int MAX_BURST = 4;
  localparam int ID_W      = 2;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [8*NUM_REQ-1:0] req_data  = '0;
  logic [NUM_REQ-1:0]   req_last  = '0;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  logic [7:0]           tx_data;
  logic                 tx_busy;
  logic [ID_W-1:0]      grant_id;
  logic                 active;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .MAX_BURST (MAX_BURST),
    .HDR_TAG   (4'hA)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_busy   (tx_busy),
    .grant_id  (grant_id),
    .active    (active)
  );

  // Transmitter: busy for 10 cycles starting the cycle after tx_start.
  int busyCnt = 0;
  always @(posedge clk) begin
    if (tx_start) busyCnt <= 10;
    else if (busyCnt != 0) busyCnt <= busyCnt - 1;
  end
  assign tx_busy = (busyCnt != 0);

  // Requester FIFOs: {last, data}
  logic [8:0] fifoMem [NUM_REQ][64];
  int         fifoHead [NUM_REQ];
  int         fifoTail [NUM_REQ];
  logic [NUM_REQ-1:0] drvAcc;

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      fifoHead[i] = 0;
      fifoTail[i] = 0;
    end
  end

  always @(posedge clk) begin
    drvAcc = req_valid & req_ready;
    #1;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (drvAcc[i]) fifoHead[i] = fifoHead[i] + 1;
      if (fifoHead[i] < fifoTail[i]) begin
        req_valid[i]       = 1'b1;
        req_data[8*i +: 8] = fifoMem[i][fifoHead[i]][7:0];
        req_last[i]        = fifoMem[i][fifoHead[i]][8];
      end else begin
        req_valid[i]       = 1'b0;
        req_data[8*i +: 8] = 8'h00;
        req_last[i]        = 1'b0;
      end
    end
  end

  // Monitor
  logic [7:0]      logByte [64];
  logic [ID_W-1:0] logId [64];
  logic [ID_W-1:0] grantLog [32];
  int logCnt = 0, grantCnt = 0, readyPulses = 0, viol = 0;
  logic monPrevBusy = 1'b0, monPrevActive = 1'b0;

  always @(posedge clk) begin
    if (tx_start) begin
      if (logCnt < 64) begin
        logByte[logCnt] = tx_data;
        logId[logCnt]   = grant_id;
      end
      logCnt = logCnt + 1;
    end
    if (tx_start && (tx_busy || monPrevBusy)) viol = viol + 1;
    if ($countones(req_ready) > 1) viol = viol + 1;
    if ((req_ready & ~req_valid) != '0) viol = viol + 1;
    readyPulses = readyPulses + $countones(req_ready);
    if (active && !monPrevActive) begin
      if (grantCnt < 32) grantLog[grantCnt] = grant_id;
      grantCnt = grantCnt + 1;
    end
    monPrevBusy   = tx_busy;
    monPrevActive = active;
  end

  // Expectations
  logic [7:0]      expByte [64];
  logic [ID_W-1:0] expId [64];
  logic [ID_W-1:0] expGrantId [32];
  int expCnt = 0, expGrantCnt = 0, expReady = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic push(input int r, input logic [7:0] b, input logic l);
    fifoMem[r][fifoTail[r]] = {l, b};
    fifoTail[r] = fifoTail[r] + 1;
  endtask

  task automatic expTx(input int id, input logic [7:0] b);
    expByte[expCnt] = b;
    expId[expCnt]   = ID_W'(id);
    expCnt   = expCnt + 1;
    expReady = expReady + 1;
  endtask

  task automatic expGrant(input int id);
    expGrantId[expGrantCnt] = ID_W'(id);
    expGrantCnt = expGrantCnt + 1;
`ifdef UART_ARB_HEADER_EN
    expByte[expCnt] = {4'hA, 2'b00, 2'(id)};
    expId[expCnt]   = ID_W'(id);
    expCnt = expCnt + 1;
`endif
  endtask

  function automatic bit allEmpty();
    for (int i = 0; i < NUM_REQ; i++)
      if (fifoHead[i] != fifoTail[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic waitIdle(input string tag, input int maxCyc);
    int n = 0;
    while (n < maxCyc && !(allEmpty() && !active && !tx_busy)) begin
      tick();
      n++;
    end
    check({tag, ".timeout"}, (n >= maxCyc) ? 32'd1 : 32'd0, 32'd0);
  endtask

  task automatic compareLogs(input string tag);
    check({tag, ".txCnt"}, logCnt, expCnt);
    for (int i = 0; i < expCnt; i++) begin
      check($sformatf("%s.byte%0d", tag, i), logByte[i], expByte[i]);
      check($sformatf("%s.id%0d", tag, i), logId[i], expId[i]);
    end
    check({tag, ".grantCnt"}, grantCnt, expGrantCnt);
    for (int i = 0; i < expGrantCnt; i++)
      check($sformatf("%s.grant%0d", tag, i), grantLog[i], expGrantId[i]);
    check({tag, ".readyCnt"}, readyPulses, expReady);
    logCnt = 0; grantCnt = 0; readyPulses = 0;
    expCnt = 0; expGrantCnt = 0; expReady = 0;
  endtask

  task automatic checkResetOutputs(input string tag);
    check({tag, ".req_ready"}, req_ready, 0);
    check({tag, ".tx_start"}, tx_start, 0);
    check({tag, ".tx_data"}, tx_data, 0);
    check({tag, ".grant_id"}, grant_id, 0);
    check({tag, ".active"}, active, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    int n;

    // Reset state
    rst = 1'b1;
    tick(3);
    checkResetOutputs("rst");
    rst = 1'b0;
    tick();
    check("rst.idleActive", active, 0);

    // Single requester, 3-byte packet
    push(0, 8'h11, 1'b0); push(0, 8'h22, 1'b0); push(0, 8'h33, 1'b1);
    expGrant(0); expTx(0, 8'h11); expTx(0, 8'h22); expTx(0, 8'h33);
    waitIdle("t2", 1000);
    compareLogs("t2");

    // Round robin from rr_ptr=0: 0,1,2,3,0
    rst = 1'b1; tick(2); rst = 1'b0; tick();
    for (int i = 0; i < NUM_REQ; i++) push(i, 8'h40 + 8'(i), 1'b1);
    push(0, 8'h44, 1'b1);
    for (int i = 0; i < NUM_REQ; i++) begin expGrant(i); expTx(i, 8'h40 + 8'(i)); end
    expGrant(0); expTx(0, 8'h44);
    waitIdle("t3", 2000);
    compareLogs("t3");

    // Move pointer to 2, then all four: 2,3,0,1
    push(1, 8'h50, 1'b1);
    expGrant(1); expTx(1, 8'h50);
    waitIdle("t3b.pre", 1000);
    for (int i = 0; i < NUM_REQ; i++) push(i, 8'h60 + 8'(i), 1'b1);
    for (int k = 0; k < NUM_REQ; k++) begin
      expGrant((k + 2) % NUM_REQ); expTx((k + 2) % NUM_REQ, 8'h60 + 8'((k + 2) % NUM_REQ));
    end
    waitIdle("t3b", 2000);
    compareLogs("t3b");

    // Burst limit 4: req 1 streams 10 bytes, req 2 interleaves
    for (int i = 0; i < 10; i++) push(1, 8'h70 + 8'(i), (i == 9));
    tick(3);
    push(2, 8'h80, 1'b1);
    expGrant(1); for (int i = 0; i < 4; i++) expTx(1, 8'h70 + 8'(i));
    expGrant(2); expTx(2, 8'h80);
    expGrant(1); for (int i = 4; i < 8; i++) expTx(1, 8'h70 + 8'(i));
    expGrant(1); expTx(1, 8'h78); expTx(1, 8'h79);
    waitIdle("t4", 3000);
    compareLogs("t4");

    // Owner stall while req 3 waits
    push(2, 8'h21, 1'b0);
    expGrant(2); expTx(2, 8'h21);
    tick(30);
    snap = logCnt;
    push(3, 8'h31, 1'b1);
    tick(50);
    check("t5.stallTx", logCnt, snap);
    check("t5.stallCnt", logCnt, expCnt);
    check("t5.grant", grant_id, 2);
    check("t5.active", active, 1);
    push(2, 8'h22, 1'b0); push(2, 8'h23, 1'b1);
    expTx(2, 8'h22); expTx(2, 8'h23);
    expGrant(3); expTx(3, 8'h31);
    waitIdle("t5", 2000);
    compareLogs("t5");

    // Single byte 5A from req 2 (header A2 first when enabled)
    push(2, 8'h5A, 1'b1);
    expGrant(2); expTx(2, 8'h5A);
    waitIdle("t6", 1000);
    compareLogs("t6");

    // Reset during WAIT with transmitter busy
    push(0, 8'h90, 1'b1);
    expGrant(0); expTx(0, 8'h90);
    n = 0;
    while (readyPulses < 1 && n < 200) begin tick(); n++; end
    check("t7.acceptTimeout", (n >= 200) ? 32'd1 : 32'd0, 32'd0);
    tick();
    check("t7.busyBeforeRst", tx_busy, 1);
    rst = 1'b1;
    tick();
    checkResetOutputs("t7.rst");
    rst = 1'b0;
    push(1, 8'h91, 1'b1);
    expGrant(1); expTx(1, 8'h91);
    waitIdle("t7", 1000);
    compareLogs("t7");

    check("protocol", viol, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
